// File: rtl/activation_pkg.sv
// Shared types for the activation controller: function codes, FSM states and
// the helper that folds unsupported function codes onto identity.
package activation_pkg;

   localparam int FuncBits = 3;

   typedef enum logic [FuncBits-1:0] {
      IDENTITY = 3'd0,
      RELU     = 3'd1
   } activ_func_e;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      RUN   = 3'd2,
      DRAIN = 3'd3,
      DONE  = 3'd4
   } act_ctrl_state_e;

   function automatic logic func_supported(input logic [FuncBits-1:0] code);
      return code <= FuncBits'(RELU);
   endfunction

   function automatic activ_func_e sanitize_func(input logic [FuncBits-1:0] code);
      return func_supported(code) ? activ_func_e'(code) : IDENTITY;
   endfunction

endpackage

// File: rtl/activation_cfg_table.sv
// Per-layer {function, batch count} register file; write lands at the clock
// edge, read is combinational, so a same-cycle reader sees the old entry.
module activation_cfg_table
   import activation_pkg::*;
#(
   parameter int LayerCount = 4,
   parameter int CountBits  = 16,
   parameter int LayerBits  = (LayerCount > 1) ? $clog2(LayerCount) : 1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 wr_vld,
   input  logic [LayerBits-1:0] wr_layer,
   input  logic [FuncBits-1:0]  wr_func,
   input  logic [CountBits-1:0] wr_batches,
   input  logic [LayerBits-1:0] rd_layer,
   output activ_func_e          rd_func,
   output logic [CountBits-1:0] rd_batches,
   output logic                 err
);

   activ_func_e          func_q    [LayerCount];
   logic [CountBits-1:0] batches_q [LayerCount];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < LayerCount; i++) begin
            func_q[i]    <= IDENTITY;
            batches_q[i] <= CountBits'(1);
         end
         err <= 1'b0;
      end else if (wr_vld) begin
         func_q[wr_layer]    <= sanitize_func(wr_func);
         batches_q[wr_layer] <= wr_batches;
         // sticky until reset so software can poll it after a burst of writes
         if (!func_supported(wr_func)) begin
            err <= 1'b1;
         end
      end
   end

   assign rd_func    = func_q[rd_layer];
   assign rd_batches = batches_q[rd_layer];

endmodule

// File: rtl/activation_controller.sv
// Sequences one layer through the fixed-latency activation datapath; results
// appear ActivLatency cycles after accept, downstream cannot stall the output.
module activation_controller
   import activation_pkg::*;
#(
   parameter  int LayerCount   = 4,
   parameter  int ActivLatency = 2,
   parameter  int CountBits    = 16,
   localparam int LayerBits    = (LayerCount > 1) ? $clog2(LayerCount) : 1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 cfg_we_i,
   input  logic [LayerBits-1:0] cfg_layer_i,
   input  logic [FuncBits-1:0]  cfg_func_i,
   input  logic [CountBits-1:0] cfg_batches_i,
   output logic                 cfg_err_o,
   input  logic                 start_i,
   input  logic [LayerBits-1:0] layer_i,
   output logic                 busy_o,
   output logic                 done_o,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   output logic                 act_en_o,
   output logic [FuncBits-1:0]  act_func_o,
   output logic                 out_valid_o,
   output logic                 out_last_o,
   output logic [CountBits-1:0] out_index_o
);

   act_ctrl_state_e         state_q, state_d;
   activ_func_e             func_q;
   activ_func_e             tbl_func;
   logic [CountBits-1:0]    tbl_batches;
   logic [CountBits-1:0]    remaining_q;
   logic [CountBits-1:0]    index_q;
   logic [ActivLatency-1:0] trk_vld_q, trk_last_q;
   logic                    accept, last_accept;

   activation_cfg_table #(
      .LayerCount (LayerCount),
      .CountBits  (CountBits),
      .LayerBits  (LayerBits)
   ) u_cfg_table (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .wr_vld     (cfg_we_i),
      .wr_layer   (cfg_layer_i),
      .wr_func    (cfg_func_i),
      .wr_batches (cfg_batches_i),
      .rd_layer   (layer_i),
      .rd_func    (tbl_func),
      .rd_batches (tbl_batches),
      .err        (cfg_err_o)
   );

   assign in_ready_o  = (state_q == RUN);
   assign accept      = in_valid_i && in_ready_o;
   assign last_accept = accept && (remaining_q == CountBits'(1));

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start_i) state_d = LOAD;
         LOAD:    state_d = (tbl_batches == '0) ? DONE : RUN;
         RUN:     if (last_accept) state_d = DRAIN;
         // only bubbles follow the last batch, so its emission means the tracker is empty
         DRAIN:   if (out_valid_o && out_last_o) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         func_q      <= IDENTITY;
         remaining_q <= '0;
         index_q     <= '0;
         trk_vld_q   <= '0;
         trk_last_q  <= '0;
      end else begin
         state_q    <= state_d;
         trk_vld_q  <= (trk_vld_q << 1) | ActivLatency'(accept);
         trk_last_q <= (trk_last_q << 1) | ActivLatency'(last_accept);
         if (state_q == LOAD) begin
            func_q      <= tbl_func;
            remaining_q <= tbl_batches;
            index_q     <= '0;
         end else begin
            if (accept) begin
               remaining_q <= remaining_q - CountBits'(1);
            end
            if (out_valid_o) begin
               index_q <= index_q + CountBits'(1);
            end
         end
      end
   end

   assign busy_o      = (state_q != IDLE);
   assign act_en_o    = busy_o;
   assign done_o      = (state_q == DONE);
   assign act_func_o  = func_q;
   assign out_valid_o = trk_vld_q[ActivLatency-1];
   assign out_last_o  = trk_last_q[ActivLatency-1];
   assign out_index_o = index_q;

endmodule

// File: tb/tb_activation_controller.sv
// Scoreboard bench: accepts queue their expected {cycle, index, last}, the
// monitor pops and compares them as results leave the controller.
module tb_activation_controller;

   localparam int L  = 2;
   localparam int LB = 2;
   localparam int CB = 16;

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b1;
   logic          cfg_we_i = 1'b0;
   logic [LB-1:0] cfg_layer_i = '0;
   logic [2:0]    cfg_func_i = '0;
   logic [CB-1:0] cfg_batches_i = '0;
   logic          cfg_err_o;
   logic          start_i = 1'b0;
   logic [LB-1:0] layer_i = '0;
   logic          busy_o, done_o;
   logic          in_valid_i = 1'b0;
   logic          in_ready_o, act_en_o;
   logic [2:0]    act_func_o;
   logic          out_valid_o, out_last_o;
   logic [CB-1:0] out_index_o;

   activation_controller #(
      .LayerCount   (4),
      .ActivLatency (L),
      .CountBits    (CB)
   ) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .cfg_we_i      (cfg_we_i),
      .cfg_layer_i   (cfg_layer_i),
      .cfg_func_i    (cfg_func_i),
      .cfg_batches_i (cfg_batches_i),
      .cfg_err_o     (cfg_err_o),
      .start_i       (start_i),
      .layer_i       (layer_i),
      .busy_o        (busy_o),
      .done_o        (done_o),
      .in_valid_i    (in_valid_i),
      .in_ready_o    (in_ready_o),
      .act_en_o      (act_en_o),
      .act_func_o    (act_func_o),
      .out_valid_o   (out_valid_o),
      .out_last_o    (out_last_o),
      .out_index_o   (out_index_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      int due;
      int idx;
      bit last;
   } exp_t;

   exp_t exp_q[$];
   exp_t e;
   int   cyc = 0;
   int   total = 0, bad = 0;
   int   n_out = 0, n_done = 0, done_cyc = -1;
   int   sb_acc = 0, acc_base = 0, sb_batches = 0;
   bit   chk_rdy_drop = 1'b0;

   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic check(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Result monitor, sampled mid-cycle.
   always @(negedge clk_i) begin
      if (chk_rdy_drop) begin
         check("rdy_drop", int'(in_ready_o), 0);
         chk_rdy_drop = 1'b0;
      end
      if (out_valid_o) begin
         n_out++;
         if (exp_q.size() == 0) begin
            check("out_spurious", int'(out_valid_o), 0);
         end else begin
            e = exp_q.pop_front();
            check("out_cycle", cyc, e.due);
            check("out_index", int'(out_index_o), e.idx);
            check("out_last", int'(out_last_o), int'(e.last));
         end
      end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
         check("out_missing", int'(out_valid_o), 1);
         void'(exp_q.pop_front());
      end
      if (!rst_i && in_valid_i && in_ready_o) begin
         exp_q.push_back('{due: cyc + L, idx: sb_acc - acc_base,
                           last: (sb_acc - acc_base == sb_batches - 1)});
         sb_acc++;
         if (sb_acc - acc_base == sb_batches) chk_rdy_drop = 1'b1;
      end
      if (done_o) begin
         n_done++;
         done_cyc = cyc;
      end
      if (rst_i) begin
         exp_q.delete();
         chk_rdy_drop = 1'b0;
      end
   end

   task automatic cfg_write(input int layer, input int func, input int batches);
      cfg_we_i      = 1'b1;
      cfg_layer_i   = LB'(layer);
      cfg_func_i    = 3'(func);
      cfg_batches_i = CB'(batches);
      tick();
      cfg_we_i = 1'b0;
   endtask

   task automatic run_job(input int layer, input int nb, input logic [7:0] pat,
                          input int plen, input int exp_func, input bit disturb);
      int t, exp_done, cnt, out0, done0;
      t        = cyc;
      exp_done = -1;
      cnt      = 0;
      if (nb == 0) exp_done = t + 2;
      else begin
         for (int j = 0; j < 64; j++) begin
            if (((j < plen) ? pat[j[2:0]] : 1'b1) && cnt < nb) begin
               cnt++;
               if (cnt == nb) exp_done = t + 2 + j + L + 1;
            end
         end
      end
      acc_base   = sb_acc;
      sb_batches = nb;
      out0       = n_out;
      done0      = n_done;
      start_i    = 1'b1;
      layer_i    = LB'(layer);
      tick();
      start_i = 1'b0;
      check("load_busy", int'(busy_o), 1);
      check("load_en", int'(act_en_o), 1);
      check("load_rdy", int'(in_ready_o), 0);
      tick();
      for (int k = 0; k < 64 && n_done == done0; k++) begin
         if (k == 0) begin
            check("func", int'(act_func_o), exp_func);
            if (nb == 0) check("zero_done_en", int'(act_en_o), 1);
         end
         in_valid_i = (k < plen) ? pat[k[2:0]] : 1'b1;
         if (disturb) begin
            start_i       = (k == 1);
            cfg_we_i      = (k == 1);
            cfg_layer_i   = LB'(layer);
            cfg_func_i    = 3'd0;
            cfg_batches_i = CB'(1);
         end
         tick();
      end
      in_valid_i = 1'b0;
      start_i    = 1'b0;
      cfg_we_i   = 1'b0;
      check("done_seen", n_done - done0, 1);
      check("done_cycle", done_cyc, exp_done);
      check("out_count", n_out - out0, nb);
      check("idle_busy", int'(busy_o), 0);
      check("idle_en", int'(act_en_o), 0);
      check("func_hold", int'(act_func_o), exp_func);
   endtask

   task automatic check_all_zero(input string pfx);
      check({pfx, "_rdy"}, int'(in_ready_o), 0);
      check({pfx, "_en"}, int'(act_en_o), 0);
      check({pfx, "_oval"}, int'(out_valid_o), 0);
      check({pfx, "_olast"}, int'(out_last_o), 0);
      check({pfx, "_done"}, int'(done_o), 0);
      check({pfx, "_busy"}, int'(busy_o), 0);
      check({pfx, "_err"}, int'(cfg_err_o), 0);
      check({pfx, "_func"}, int'(act_func_o), 0);
      check({pfx, "_idx"}, int'(out_index_o), 0);
   endtask

   initial begin
      int out0, done0;
      repeat (3) tick();
      rst_i = 1'b0;
      tick();
      check_all_zero("reset");

      // basic ReLU job, input always valid
      cfg_write(2, 1, 3);
      run_job(2, 3, 8'hFF, 8, 1, 1'b0);

      // bubbled input 1,0,1,1
      cfg_write(1, 1, 3);
      run_job(1, 3, 8'b0000_1101, 4, 1, 1'b0);

      // zero-batch job
      cfg_write(0, 0, 0);
      run_job(0, 0, 8'h00, 8, 0, 1'b0);

      // unsupported function code
      check("err_before", int'(cfg_err_o), 0);
      cfg_write(1, 5, 2);
      check("err_set", int'(cfg_err_o), 1);
      run_job(1, 2, 8'hFF, 8, 0, 1'b0);
      check("err_sticky", int'(cfg_err_o), 1);

      // start pulse and rewrite of the active entry while running
      cfg_write(3, 1, 4);
      run_job(3, 4, 8'hFF, 8, 1, 1'b1);
      run_job(3, 1, 8'hFF, 8, 0, 1'b0);

      // reset while the last batch is in flight
      acc_base   = sb_acc;
      sb_batches = 3;
      out0       = n_out;
      done0      = n_done;
      start_i    = 1'b1;
      layer_i    = LB'(2);
      tick();
      start_i = 1'b0;
      tick();
      in_valid_i = 1'b1;
      for (int c = 0; c < 20 && (sb_acc - acc_base) < 3; c++) tick();
      in_valid_i = 1'b0;
      check("drain_busy", int'(busy_o), 1);
      check("drain_rdy", int'(in_ready_o), 0);
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      check_all_zero("midrst");
      repeat (4) tick();
      check("midrst_outs", n_out - out0, 2);
      check("midrst_nodone", n_done - done0, 0);
      run_job(2, 1, 8'hFF, 8, 0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
      $fatal(1);
   end

endmodule
